mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single-port 256x32 word memory between instruction fetch (IF, read-only) and the load/store unit (DM, read/write).
- Requesters use a 32-bit byte address with valid/ready request handshake. Responses are fixed-latency (1 cycle) with no backpressure.
- Sits between the core and the memory; drives the memory's request/we_re/address/data_in/mask pins and returns its data_out.
- Sustains one transaction per cycle.

Parameters:
- ADDR_W, 8, memory word-address width; legal byte range is 0 .. 4*2^ADDR_W-1.

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch granted this cycle
- if_req_addr  in  32  fetch byte address
- if_rsp_valid  out  1  fetch response
- if_rsp_rdata  out  32  fetch read data
- if_rsp_err  out  1  fetch address out of range
- dm_req_valid  in  1  data request
- dm_req_ready  out  1  data granted this cycle
- dm_req_we  in  1  1=store, 0=load
- dm_req_addr  in  32  data byte address
- dm_req_wdata  in  32  store data
- dm_req_mask  in  4  store byte enables
- dm_rsp_valid  out  1  data response (load data or store ack)
- dm_rsp_rdata  out  32  load data
- dm_rsp_err  out  1  data address out of range
- mem_request  out  1  to memory request
- mem_we_re  out  1  to memory we_re
- mem_address  out  ADDR_W  to memory address (word index)
- mem_data_in  out  32  to memory data_in
- mem_mask  out  4  to memory mask
- mem_data_out  in  32  from memory data_out

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values:
  - rsp state = IDLE.
  - All *_rsp_valid = 0, *_rsp_err = 0, *_rsp_rdata = 0.
  - Priority pointer = DM.
- Grant (combinational, same cycle):
  - At most one of if_req_ready/dm_req_ready is high.
  - Ready is high only if the matching valid is high and that requester wins.
  - Default is fixed priority: DM beats IF.
  - Grant does not depend on response state. Back-to-back grants are allowed every cycle.
- Handshake:
  - Transfer occurs when valid & ready.
  - Requester holds request fields stable until ready.
  - Requester may drop valid without a transfer.
- Range check:
  - err_now = |addr[31:ADDR_W+2].
  - addr[1:0] is ignored; the word index is addr[ADDR_W+1:2].
- Memory drive, in the grant cycle only:
  - In range: mem_request = 1, mem_address = word index, mem_we_re = dm_req_we for DM or 0 for IF.
  - Out of range: mem_request = 0.
  - mem_data_in and mem_mask = DM fields when DM is granted, else 0.
  - No grant: mem_request = 0, other mem_* outputs = 0.
- Response FSM, 1-cycle latency (state registered from the grant cycle):
  - IDLE: no response this cycle.
  - RSP_IF: if_rsp_valid = 1, if_rsp_rdata = err ? 0 : mem_data_out.
  - RSP_DM: dm_rsp_valid = 1. dm_rsp_rdata = mem_data_out for an in-range load, 0 for a store or on err.
  - *_rsp_err = registered err_now.
- Transitions:
  - next = RSP_DM if DM granted, RSP_IF if IF granted, else IDLE.
  - Every state can move to every state.
- Response path: rsp_valid is a one-cycle pulse; the requester must accept it.
- rdata routing:
  - rdata is combinational from mem_data_out in the response cycle.
  - A new read issued in that same cycle updates mem_data_out only at the following edge, so it never corrupts the current response.
- Writes:
  - Memory commits at the grant-cycle edge.
  - A DM load of the same word in the next cycle returns the new data.
- Reset mid-operation:
  - A pending response is dropped; state = IDLE after the reset edge.
  - No grants while rst = 1 (both ready = 0, mem_request = 0).

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit priority pointer selects the preferred requester.
  - After any granted transfer, the pointer moves to the other requester.
  - A lone valid requester is always granted.
  - With both valid continuously, grants alternate DM, IF, DM, IF, ...
  - Reset sets the pointer to DM.
- Undefined: fixed DM-over-IF priority; pointer logic is absent.

Test Plan:
- IF-only read:
  - Preload word 5 = 0xDEADBEEF.
  - if_req_addr = 0x14, valid 1 cycle -> if_req_ready = 1 in the same cycle; next cycle if_rsp_valid = 1, rdata = 0xDEADBEEF, err = 0.
- DM store then load, back-to-back:
  - Store addr 0x20, wdata 0x11223344, mask 4'b0101; word 8 initially 0xAAAAAAAA.
  - Next cycle, load 0x20 -> store ack with rdata = 0, then load rsp rdata = 0xAA22AA44.
- Contention, fixed priority:
  - Both valid for 3 cycles (IF 0x0, DM load 0x4) -> dm_req_ready = 1 all 3 cycles, if_req_ready = 0.
  - IF is granted only in the cycle after DM drops valid.
- Contention with MEM_ARB_RR_EN:
  - Same stimulus for 4 cycles -> grants DM, IF, DM, IF.
  - Responses appear one cycle after each grant on the matching port.
- Out of range:
  - dm load addr 0x400 -> mem_request = 0 in the grant cycle.
  - Next cycle dm_rsp_valid = 1, err = 1, rdata = 0; memory contents unchanged.
- Reset mid-operation:
  - IF read granted at cycle N, rst = 1 at cycle N+1 -> if_rsp_valid = 0 at N+1 and after.
  - Both ready = 0 while rst = 1; normal grants resume the cycle after rst falls.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 2^ADDR_W x 32 word memory between
// instruction fetch (IF, read-only) and the load/store unit (DM).
//
// Request handshake: a requester raises *_req_valid with stable fields; a
// transfer happens in the cycle where *_req_valid and *_req_ready are both
// high. The granted request drives the memory pins in that same cycle. The
// requester may drop valid before it is granted. Responses come exactly one
// cycle after the grant as a one-cycle *_rsp_valid pulse with no
// backpressure.
//
// Optional build macro: MEM_ARB_RR_EN
//   defined   -> round-robin arbitration through a 1-bit priority pointer
//   undefined -> fixed priority, DM beats IF
module mem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [31:0]       if_req_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_rdata,
  output logic              if_rsp_err,
  // load/store port
  input  logic              dm_req_valid,
  output logic              dm_req_ready,
  input  logic              dm_req_we,
  input  logic [31:0]       dm_req_addr,
  input  logic [31:0]       dm_req_wdata,
  input  logic [3:0]        dm_req_mask,
  output logic              dm_rsp_valid,
  output logic [31:0]       dm_rsp_rdata,
  output logic              dm_rsp_err,
  // memory side
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic [3:0]        mem_mask,
  input  logic [31:0]       mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RSP_IF = 2'd1,
    RSP_DM = 2'd2
  } rsp_state_e;

  // Response-side state in one struct so checkers can bind to a single signal.
  typedef struct packed {
    rsp_state_e state;  // which port answers this cycle
    logic       err;    // registered out-of-range flag of the granted request
    logic       we;     // granted DM request was a store
  } rsp_dbg_t;

  rsp_dbg_t rsp_q, rsp_d;

  logic              if_err_now, dm_err_now;
  logic [ADDR_W-1:0] if_word, dm_word;
  logic              dm_win, if_win;
  logic              gnt_if, gnt_dm;
  logic              unused_addr_bits;

  // Address decode: everything above the word index must be zero.
  assign if_err_now = |if_req_addr[31:ADDR_W+2];
  assign dm_err_now = |dm_req_addr[31:ADDR_W+2];
  assign if_word    = if_req_addr[ADDR_W+1:2];
  assign dm_word    = dm_req_addr[ADDR_W+1:2];
  // Byte offset within a word has no meaning to a word memory.
  assign unused_addr_bits = ^{if_req_addr[1:0], dm_req_addr[1:0]};

`ifdef MEM_ARB_RR_EN
  // 1 = IF is the preferred requester on a tie, 0 = DM is preferred.
  logic prio_if_q, prio_if_d;

  // Round-robin pick: a lone requester always wins; on a tie the pointer decides.
  always_comb begin
    dm_win = dm_req_valid & (~if_req_valid | ~prio_if_q);
    if_win = if_req_valid & ~dm_win;
  end

  // After any transfer the other requester becomes preferred.
  always_comb begin
    prio_if_d = prio_if_q;
    if (gnt_dm) prio_if_d = 1'b1;
    else if (gnt_if) prio_if_d = 1'b0;
  end

  // Priority pointer register, DM preferred out of reset.
  always_ff @(posedge clk) begin
    if (rst) prio_if_q <= 1'b0;
    else     prio_if_q <= prio_if_d;
  end
`else
  // Fixed priority pick: DM always beats IF.
  always_comb begin
    dm_win = dm_req_valid;
    if_win = if_req_valid & ~dm_req_valid;
  end
`endif

  // Grants are independent of the response state; nothing is granted in reset.
  assign gnt_dm       = dm_win & ~rst;
  assign gnt_if       = if_win & ~rst;
  assign dm_req_ready = gnt_dm;
  assign if_req_ready = gnt_if;

  // Drive the memory pins from the granted request in the grant cycle only.
  always_comb begin
    mem_request = 1'b0;
    mem_we_re   = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    mem_mask    = '0;
    if (gnt_dm) begin
      mem_request = ~dm_err_now;
      mem_we_re   = dm_req_we;
      mem_address = dm_word;
      mem_data_in = dm_req_wdata;
      mem_mask    = dm_req_mask;
    end else if (gnt_if) begin
      mem_request = ~if_err_now;
      mem_address = if_word;
    end
  end

  // Next response state: whoever is granted now answers next cycle.
  always_comb begin
    rsp_d       = rsp_q;
    rsp_d.state = IDLE;
    rsp_d.err   = 1'b0;
    rsp_d.we    = 1'b0;
    if (gnt_dm) begin
      rsp_d.state = RSP_DM;
      rsp_d.err   = dm_err_now;
      rsp_d.we    = dm_req_we;
    end else if (gnt_if) begin
      rsp_d.state = RSP_IF;
      rsp_d.err   = if_err_now;
    end
  end

  // Response state register; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q.state <= IDLE;
      rsp_q.err   <= 1'b0;
      rsp_q.we    <= 1'b0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  // Response outputs. Read data is taken combinationally from the memory in
  // the response cycle; a read launched this cycle only changes mem_data_out
  // at the next edge. Asserting rst suppresses a response already in flight.
  always_comb begin
    if_rsp_valid = 1'b0;
    if_rsp_err   = 1'b0;
    if_rsp_rdata = '0;
    dm_rsp_valid = 1'b0;
    dm_rsp_err   = 1'b0;
    dm_rsp_rdata = '0;
    if (!rst) begin
      if (rsp_q.state == RSP_IF) begin
        if_rsp_valid = 1'b1;
        if_rsp_err   = rsp_q.err;
        if_rsp_rdata = rsp_q.err ? 32'd0 : mem_data_out;
      end else if (rsp_q.state == RSP_DM) begin
        dm_rsp_valid = 1'b1;
        dm_rsp_err   = rsp_q.err;
        dm_rsp_rdata = (rsp_q.err || rsp_q.we) ? 32'd0 : mem_data_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, a
// behavioural memory hanging off the memory pins, and a scoreboard that
// predicts grants and responses from the arbitration rules.
module tb_mem_arbiter;

  localparam int ADDR_W = 8;
  localparam int WORDS  = 1 << ADDR_W;
  localparam int BYTES  = 4 * WORDS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              if_req_valid = 1'b0, if_req_ready;
  logic [31:0]       if_req_addr = '0;
  logic              if_rsp_valid, if_rsp_err;
  logic [31:0]       if_rsp_rdata;
  logic              dm_req_valid = 1'b0, dm_req_ready, dm_req_we = 1'b0;
  logic [31:0]       dm_req_addr = '0, dm_req_wdata = '0;
  logic [3:0]        dm_req_mask = '0;
  logic              dm_rsp_valid, dm_rsp_err;
  logic [31:0]       dm_rsp_rdata;
  logic              mem_request, mem_we_re;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in;
  logic [3:0]        mem_mask;
  logic [31:0]       mem_data_out = '0;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata), .if_rsp_err(if_rsp_err),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_we(dm_req_we),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_mask(dm_req_mask),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata), .dm_rsp_err(dm_rsp_err),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_mask(mem_mask), .mem_data_out(mem_data_out)
  );

  // ---------------- behavioural single-port memory ----------------
  logic [31:0] sim_mem [WORDS];
  always @(posedge clk) begin
    if (mem_request) begin
      if (mem_we_re) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) sim_mem[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
      end else begin
        mem_data_out <= sim_mem[mem_address];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [WORDS];
  // entry = {due_cycle[31:0], err, rdata[31:0]}
  logic [64:0] if_exp_q[$];
  logic [64:0] dm_exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Predictor: decides the expected winner from the arbitration rules, checks
  // the grant and memory pins, and queues the response due one cycle later.
  bit pref_dm = 1'b1;
  always @(negedge clk) begin
    int          winner;  // 0 none, 1 IF, 2 DM
    logic [31:0] a;
    logic        oor;
    int          idx;
    logic [31:0] rd;
    if (rst) begin
      chk("rst_if_ready", {31'd0, if_req_ready}, 32'd0);
      chk("rst_dm_ready", {31'd0, dm_req_ready}, 32'd0);
      chk("rst_mem_request", {31'd0, mem_request}, 32'd0);
      pref_dm = 1'b1;
    end else begin
      winner = 0;
      if (dm_req_valid && if_req_valid) begin
`ifdef MEM_ARB_RR_EN
        winner = pref_dm ? 2 : 1;
`else
        winner = 2;
`endif
      end else if (dm_req_valid) winner = 2;
      else if (if_req_valid) winner = 1;
      chk("if_ready", {31'd0, if_req_ready}, {31'd0, winner == 1});
      chk("dm_ready", {31'd0, dm_req_ready}, {31'd0, winner == 2});
      if (winner == 0) begin
        chk("idle_mem_pins", {mem_request, mem_we_re, 2'd0, mem_mask, 16'd0, mem_address},
            32'd0);
        chk("idle_mem_data_in", mem_data_in, 32'd0);
      end else begin
        a   = (winner == 2) ? dm_req_addr : if_req_addr;
        oor = (a >= BYTES);
        idx = int'(a / 4) % WORDS;
        chk("mem_request", {31'd0, mem_request}, {31'd0, !oor});
        if (!oor) begin
          chk("mem_address", {24'd0, mem_address}, idx);
          chk("mem_we_re", {31'd0, mem_we_re}, {31'd0, winner == 2 && dm_req_we});
        end
        chk("mem_data_in", mem_data_in, (winner == 2) ? dm_req_wdata : 32'd0);
        chk("mem_mask", {28'd0, mem_mask}, (winner == 2) ? {28'd0, dm_req_mask} : 32'd0);
        rd = 32'd0;
        if (!oor) begin
          if (winner == 2 && dm_req_we) begin
            for (int b = 0; b < 4; b++)
              if (dm_req_mask[b]) ref_mem[idx][8*b +: 8] = dm_req_wdata[8*b +: 8];
          end else begin
            rd = ref_mem[idx];
          end
        end
        if (winner == 2) dm_exp_q.push_back({cyc + 1, oor, rd});
        else             if_exp_q.push_back({cyc + 1, oor, rd});
        pref_dm = (winner == 1);
      end
    end
  end

  // Monitor: compares whatever each response port shows against the queue.
  always @(negedge clk) begin
    logic [64:0] e;
    bit          due;
    // instruction fetch port
    due = (if_exp_q.size() > 0) && (if_exp_q[0][64:33] == cyc);
    if (rst) begin
      if (due) void'(if_exp_q.pop_front());
      chk("rst_if_rsp", {if_rsp_valid, if_rsp_err, 30'd0}, 32'd0);
      chk("rst_if_rdata", if_rsp_rdata, 32'd0);
    end else if (due) begin
      e = if_exp_q.pop_front();
      chk("if_rsp_valid", {31'd0, if_rsp_valid}, 32'd1);
      chk("if_rsp_err", {31'd0, if_rsp_err}, {31'd0, e[32]});
      chk("if_rsp_rdata", if_rsp_rdata, e[31:0]);
    end else begin
      chk("if_rsp_spurious", {31'd0, if_rsp_valid}, 32'd0);
    end
    // load/store port
    due = (dm_exp_q.size() > 0) && (dm_exp_q[0][64:33] == cyc);
    if (rst) begin
      if (due) void'(dm_exp_q.pop_front());
      chk("rst_dm_rsp", {dm_rsp_valid, dm_rsp_err, 30'd0}, 32'd0);
      chk("rst_dm_rdata", dm_rsp_rdata, 32'd0);
    end else if (due) begin
      e = dm_exp_q.pop_front();
      chk("dm_rsp_valid", {31'd0, dm_rsp_valid}, 32'd1);
      chk("dm_rsp_err", {31'd0, dm_rsp_err}, {31'd0, e[32]});
      chk("dm_rsp_rdata", dm_rsp_rdata, e[31:0]);
    end else begin
      chk("dm_rsp_spurious", {31'd0, dm_rsp_valid}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic v, input logic [31:0] a);
    if_req_valid = v;
    if_req_addr  = a;
  endtask

  task automatic set_dm(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m);
    dm_req_valid = v;
    dm_req_we    = we;
    dm_req_addr  = a;
    dm_req_wdata = wd;
    dm_req_mask  = m;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom | 32'h0000_0400;
    return $urandom_range(0, BYTES - 1);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int mism;
    bit g_if, g_dm;
    for (int i = 0; i < WORDS; i++) begin
      sim_mem[i] = $urandom;
      ref_mem[i] = sim_mem[i];
    end
    sim_mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    sim_mem[8] = 32'hAAAAAAAA; ref_mem[8] = 32'hAAAAAAAA;
    sim_mem[1] = 32'h0BADF00D; ref_mem[1] = 32'h0BADF00D;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // IF-only read of word 5
    set_if(1'b1, 32'h14); tick();
    set_if(1'b0, 32'h0);  tick();

    // store to word 8, then load it back the following cycle
    set_dm(1'b1, 1'b1, 32'h20, 32'h11223344, 4'b0101); tick();
    set_dm(1'b1, 1'b0, 32'h20, 32'h0, 4'b0000);        tick();
    set_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);         tick();

    // contention: both valid, then DM drops and IF keeps asking
    set_if(1'b1, 32'h0);
    set_dm(1'b1, 1'b0, 32'h4, 32'h0, 4'b0000);
    repeat (4) tick();
    set_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000); tick();
    set_if(1'b0, 32'h0); tick();

    // out-of-range load and store
    set_dm(1'b1, 1'b0, 32'h400, 32'h0, 4'b0000);        tick();
    set_dm(1'b1, 1'b1, 32'h8000_0000, 32'hFFFFFFFF, 4'b1111); tick();
    set_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);          tick();

    // reset while an IF response is pending, requests held through reset
    set_if(1'b1, 32'h14); tick();
    rst = 1'b1;
    set_if(1'b1, 32'h0);
    set_dm(1'b1, 1'b0, 32'h4, 32'h0, 4'b0000);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    set_if(1'b0, 32'h0);
    set_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
    tick();

    // random traffic: held fields until granted, occasional drops and resets
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      g_if = if_req_ready;
      g_dm = dm_req_ready;
      tick();
      rst = ($urandom_range(0, 99) == 0);
      if (!if_req_valid || g_if) set_if($urandom_range(0, 1) == 1, rand_addr());
      else if ($urandom_range(0, 7) == 0) if_req_valid = 1'b0;
      if (!dm_req_valid || g_dm)
        set_dm($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rand_addr(),
               $urandom, 4'($urandom_range(0, 15)));
      else if ($urandom_range(0, 7) == 0) dm_req_valid = 1'b0;
    end

    rst = 1'b0;
    set_if(1'b0, 32'h0);
    set_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
    repeat (3) tick();

    @(negedge clk);
    chk("if_queue_drained", if_exp_q.size(), 32'd0);
    chk("dm_queue_drained", dm_exp_q.size(), 32'd0);
    mism = 0;
    for (int i = 0; i < WORDS; i++) if (sim_mem[i] !== ref_mem[i]) mism++;
    chk("mem_contents_mismatched_words", mism, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
